// File: rtl/mem_stage_ls.sv
// mem_stage_ls: EX/MEM pipeline register plus byte/half/word load-store unit over a req/ack data port
module mem_stage_ls #(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [31:0]       ex_store_data,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_sel,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              we_out,
    output logic [REG_AW-1:0] waddr_out,
    output logic [31:0]       wdata_out,
    output logic              exc_misalign,
    output logic              bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);
    state_t state_q, state_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              mis_q, mis_d, tmo_q, tmo_d, fpend_q, fpend_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pending, is_load, is_store, is_byte, is_half, is_word;
    logic              misalign, start, active, done;
    logic [1:0]        lane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_v, store_v;
    logic [3:0]        sel_v;
    always_comb begin
        pending  = (op_q != 4'd0) && (op_q <= 4'd8);
        is_load  = (op_q != 4'd0) && (op_q <= 4'd5);
        is_store = (op_q >= 4'd6) && (op_q <= 4'd8);
        is_byte  = (op_q == 4'd1) || (op_q == 4'd2) || (op_q == 4'd6);
        is_half  = (op_q == 4'd3) || (op_q == 4'd4) || (op_q == 4'd7);
        is_word  = (op_q == 4'd5) || (op_q == 4'd8);
        lane     = addr_q[1:0];
        misalign = (is_half && lane[0]) || (is_word && lane != 2'd0);
        // a flush arriving before the request goes out cancels it instead of starting a bus cycle
        start    = (state_q == S_IDLE) && pending && !flush;
        active   = (start && !misalign) || (state_q == S_WAIT);
        done     = (state_q == S_DONE);
        stall_req = pending && !done;
    end
    always_comb begin
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        if ((flush && state_q != S_WAIT) || (done && fpend_q)) begin
            we_d    = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            op_d    = 4'd0;
            addr_d  = '0;
            sdata_d = '0;
        end else if (!stall_req) begin
            we_d    = ex_we;
            waddr_d = ex_waddr;
            wdata_d = ex_wdata;
            op_d    = ex_mem_op;
            addr_d  = ex_mem_addr;
            sdata_d = ex_store_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            op_q    <= 4'd0;
            addr_q  <= '0;
            sdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
            fpend_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
            fpend_q <= fpend_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start && misalign) begin
                    state_d = S_DONE;
                    mis_d   = 1'b1;
                end else if (start && mem_ack) begin
                    state_d = S_DONE;
                    rdata_d = mem_rdata;
                end else if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    rdata_d = mem_rdata;
                end else if (cnt_q >= TMO) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        fpend_d = (state_d == S_IDLE) ? 1'b0 : (fpend_q || (state_q == S_WAIT && flush));
    end
    always_comb begin
        byte_v  = rdata_q[{lane, 3'b000} +: 8];
        half_v  = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_v  = (op_q == 4'd1) ? {{24{byte_v[7]}}, byte_v} :
                  (op_q == 4'd2) ? {24'd0, byte_v} :
                  (op_q == 4'd3) ? {{16{half_v[15]}}, half_v} :
                  (op_q == 4'd4) ? {16'd0, half_v} : rdata_q;
        store_v = is_byte ? {4{sdata_q[7:0]}} : is_half ? {2{sdata_q[15:0]}} : sdata_q;
        sel_v   = is_byte ? (4'b0001 << lane) : is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mem_req   = active;
        mem_wr    = active && is_store;
        mem_addr  = active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata = (active && is_store) ? store_v : '0;
        mem_sel   = active ? sel_v : 4'd0;
        we_out    = done ? (we_q && is_load && !mis_q && !tmo_q && !fpend_q && !flush) : (we_q && !stall_req);
        waddr_out = waddr_q;
        wdata_out = (done && is_load) ? load_v : wdata_q;
        exc_misalign = done && mis_q;
        bus_err      = done && tmo_q;
    end
endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: directed load/store vectors with queued expectations checked by a monitor
module tb_mem_stage_ls;
    logic        clk = 1'b0;
    logic        rst, flush, ex_we, mem_ack;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata, ex_mem_addr, ex_store_data, mem_rdata;
    logic [3:0]  ex_mem_op;
    logic        stall_req, mem_req, mem_wr, we_out, exc_misalign, bus_err;
    logic [31:0] mem_addr, mem_wdata, wdata_out;
    logic [3:0]  mem_sel;
    logic [4:0]  waddr_out;
    typedef struct packed {logic we; logic [4:0] waddr; logic [31:0] wdata; logic exc; logic err;} res_t;
    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel;} bus_t;
    res_t res_q[$];
    bus_t bus_q[$];
    int   errors = 0, checks = 0;
    logic req_prev = 1'b0;
    always #5 clk = ~clk;
    mem_stage_ls #(.ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_we(ex_we), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
        .ex_store_data(ex_store_data), .stall_req(stall_req), .mem_req(mem_req),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .we_out(we_out), .waddr_out(waddr_out),
        .wdata_out(wdata_out), .exc_misalign(exc_misalign), .bus_err(bus_err)
    );
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push_res(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic exc, input logic err);
        res_q.push_back('{we, wa, wd, exc, err});
    endtask
    task automatic push_bus(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sel);
        bus_q.push_back('{wr, a, wd, sel});
    endtask
    task automatic clear_ex();
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_mem_op = '0; ex_mem_addr = '0; ex_store_data = '0;
    endtask
    task automatic issue(input logic [3:0] op, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                         input int ack_k, input int flush_k, input int exp_stall, input int exp_req, input string name);
        int st = 0, rq = 0;
        @(negedge clk);
        ex_mem_op = op; ex_we = we; ex_waddr = wa; ex_wdata = wd; ex_mem_addr = addr; ex_store_data = sd;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) clear_ex();
            mem_ack = (k == ack_k); mem_rdata = rd; flush = (k == flush_k);
            #1;
            if (mem_req) rq++;
            if (!stall_req) break;
            st++;
        end
        mem_ack = 1'b0; flush = 1'b0;
        chk({name, "_stall_cycles"}, 128'(st), 128'(exp_stall));
        chk({name, "_req_cycles"}, 128'(rq), 128'(exp_req));
    endtask
    initial begin
        bus_t b;
        res_t r;
        forever begin
            @(negedge clk);
            #2;
            if (mem_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bus: got addr %0h wr %0b, required no request", mem_addr, mem_wr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_req", {mem_wr, mem_addr, mem_wdata, mem_sel}, b);
                end
            end
            req_prev = mem_req;
            if (we_out || exc_misalign || bus_err) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got we %0b exc %0b err %0b, required none", we_out, exc_misalign, bus_err);
                end else begin
                    r = res_q.pop_front();
                    chk("res_flags", {we_out, exc_misalign, bus_err}, {r.we, r.exc, r.err});
                    if (r.we) chk("res_wb", {waddr_out, wdata_out}, {r.waddr, r.wdata});
                end
            end
        end
    end
    initial begin
        rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        clear_ex();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {stall_req, mem_req, mem_wr, mem_sel, we_out, exc_misalign, bus_err}, '0);
        chk("reset_data", {mem_addr, mem_wdata, waddr_out, wdata_out}, '0);
        rst = 1'b0;
        push_res(1'b1, 5'd3, 32'h1234, 1'b0, 1'b0);
        issue(4'd0, 1'b1, 5'd3, 32'h1234, 32'h0, 32'h0, 32'h0, -1, -1, 0, 0, "add");
        push_bus(1'b0, 32'h100, 32'h0, 4'b1000);
        push_res(1'b1, 5'd5, 32'hFFFFFF80, 1'b0, 1'b0);
        issue(4'd1, 1'b1, 5'd5, 32'h0, 32'h103, 32'h0, 32'h80FFFFFF, 2, -1, 3, 3, "lb");
        push_bus(1'b0, 32'h100, 32'h0, 4'b1000);
        push_res(1'b1, 5'd6, 32'h00000080, 1'b0, 1'b0);
        issue(4'd2, 1'b1, 5'd6, 32'h0, 32'h103, 32'h0, 32'h80FFFFFF, 2, -1, 3, 3, "lbu");
        push_bus(1'b1, 32'h200, 32'hABCDABCD, 4'b1100);
        issue(4'd7, 1'b1, 5'd7, 32'h0, 32'h202, 32'h0000ABCD, 32'h0, 0, -1, 1, 1, "sh");
        push_res(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        issue(4'd5, 1'b1, 5'd8, 32'h0, 32'h006, 32'h0, 32'h0, -1, -1, 1, 0, "lw_misalign");
        push_bus(1'b0, 32'h040, 32'h0, 4'b1111);
        push_res(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        issue(4'd5, 1'b1, 5'd9, 32'h0, 32'h040, 32'h0, 32'h0, -1, -1, 5, 5, "lw_timeout");
        push_bus(1'b0, 32'h010, 32'h0, 4'b1100);
        push_res(1'b1, 5'd9, 32'h000089AB, 1'b0, 1'b0);
        issue(4'd4, 1'b1, 5'd9, 32'h0, 32'h012, 32'h0, 32'h89AB0000, 1, -1, 2, 2, "lhu");
        push_bus(1'b0, 32'h010, 32'h0, 4'b1100);
        push_res(1'b1, 5'd10, 32'hFFFF89AB, 1'b0, 1'b0);
        issue(4'd3, 1'b1, 5'd10, 32'h0, 32'h012, 32'h0, 32'h89AB0000, 1, -1, 2, 2, "lh");
        push_bus(1'b1, 32'h300, 32'h77777777, 4'b0010);
        issue(4'd6, 1'b0, 5'd0, 32'h0, 32'h301, 32'h12345677, 32'h0, 1, -1, 2, 2, "sb");
        push_bus(1'b1, 32'h404, 32'hDEADBEEF, 4'b1111);
        issue(4'd8, 1'b0, 5'd0, 32'h0, 32'h404, 32'hDEADBEEF, 32'h0, 0, -1, 1, 1, "sw");
        push_bus(1'b0, 32'h404, 32'h0, 4'b1111);
        push_res(1'b1, 5'd11, 32'hCAFEF00D, 1'b0, 1'b0);
        issue(4'd5, 1'b1, 5'd11, 32'h0, 32'h404, 32'h0, 32'hCAFEF00D, 1, -1, 2, 2, "lw");
        push_bus(1'b0, 32'h300, 32'h0, 4'b1100);
        issue(4'd3, 1'b1, 5'd12, 32'h0, 32'h302, 32'h0, 32'h80000000, 3, 1, 4, 4, "lh_flush");
        @(negedge clk);
        #1;
        chk("flush_bubble", {we_out, stall_req, waddr_out}, '0);
        push_res(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        issue(4'd7, 1'b1, 5'd13, 32'h0, 32'h203, 32'h1, 32'h0, -1, -1, 1, 0, "sh_misalign");
        push_res(1'b1, 5'd12, 32'h55, 1'b0, 1'b0);
        issue(4'd9, 1'b1, 5'd12, 32'h55, 32'h003, 32'h0, 32'h0, -1, -1, 0, 0, "op9");
        push_bus(1'b0, 32'h500, 32'h0, 4'b1111);
        @(negedge clk);
        ex_mem_op = 4'd5; ex_we = 1'b1; ex_waddr = 5'd14; ex_mem_addr = 32'h500;
        @(negedge clk);
        clear_ex();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_ctrl", {stall_req, mem_req, mem_wr, mem_sel, we_out, exc_misalign, bus_err}, '0);
        chk("rst_mid_data", {mem_addr, mem_wdata, waddr_out, wdata_out}, '0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("bus_queue_empty", 128'(bus_q.size()), '0);
        chk("res_queue_empty", 128'(res_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ls.md
Name: mem_stage_ls

Overview:
Parametrised successor to the pass-through EX/MEM register and MEM stage. Latches the EX result with stall and flush control, then executes byte, half and word loads and stores over a req/ack data-memory port. A three-state FSM holds the pipeline until the access completes, times out, or is rejected as misaligned. Sits between EX and MEM/WB and drives the hazard unit's stall input.

Parameters:
ADDR_W, 32, data-address width (at least 3)
REG_AW, 5, register-file address width
TIMEOUT_CYC, 255, maximum WAIT cycles before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard the latched instruction (insert bubble)
ex_we  in  1  EX register-write enable
ex_waddr  in  REG_AW  EX destination register
ex_wdata  in  32  EX ALU result
ex_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as none
ex_mem_addr  in  ADDR_W  effective byte address
ex_store_data  in  32  store source data
stall_req  out  1  hold upstream stages
mem_req  out  1  memory request
mem_wr  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
mem_wdata  out  32  lane-positioned store data
mem_sel  out  4  byte enables, bit i = byte lane i
mem_ack  in  1  access complete, one cycle
mem_rdata  in  32  read data, valid with mem_ack
we_out  out  1  writeback enable to MEM/WB
waddr_out  out  REG_AW  writeback register
wdata_out  out  32  writeback data
exc_misalign  out  1  one-cycle misaligned-access flag
bus_err  out  1  one-cycle timeout flag

Behaviour:
- Pipeline register (posedge clk): rst clears all fields, op = none. Else, if flush and state is not WAIT, clear. Else, if stall_req = 0, capture ex_*. Else hold.
- Mem op pending = latched op in 1..8.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, no mem op:
  - Outputs pass the latched we/waddr/wdata through combinationally.
  - stall_req = 0.
- IDLE, mem op pending and misaligned (half with addr[0] = 1, word with addr[1:0] != 0):
  - No request issued.
  - Next state DONE with fault = misalign.
- IDLE, mem op pending and aligned:
  - mem_req = 1 combinationally; mem_wr = op is 6..8.
  - If mem_ack is high the same cycle, go to DONE; else go to WAIT.
- WAIT:
  - mem_req is held high; address, data and enables stay stable.
  - A cycle counter starts at 1.
  - On mem_ack: register load data, go to DONE.
  - When the counter reaches TIMEOUT_CYC with no ack: drop mem_req, go to DONE with fault = timeout.
- DONE:
  - stall_req = 0; exactly one cycle, then IDLE.
  - Loads: we_out = latched we, wdata_out = extracted load data.
  - Stores: we_out = 0.
  - Any fault, or a pending flush: we_out = 0.
  - exc_misalign or bus_err is high for this cycle only.
- stall_req = mem op pending AND state != DONE.
- Flush during WAIT:
  - Latched as flush_pending; the bus transaction is never abandoned.
  - On completion, DONE forces we_out = 0, then the register clears. flush_pending is cleared on entering IDLE.
- Load extraction (little-endian, lane = addr[1:0]):
  - LB / LBU: byte from the lane, sign- or zero-extended.
  - LH / LHU: half from lane 0 or 2, sign- or zero-extended.
  - LW: full word.
- Store formatting:
  - SB: byte replicated to all 4 lanes, mem_sel = 1 << lane.
  - SH: half replicated to both halves, mem_sel = 0011 or 1100.
  - SW: mem_sel = 1111.
- Outputs while stalled: we_out = 0. When idle, mem_req, mem_wr, mem_sel and mem_wdata are 0.
- Reset mid-transaction: FSM goes to IDLE, all outputs 0. The memory slave must tolerate an abandoned request.
- Reset values: every output is 0.

Test Plan:
- ADD result (we = 1, waddr = 3, wdata = 0x1234) with op 0 → one cycle after capture: we_out = 1, waddr_out = 3, wdata_out = 0x1234; stall_req never asserts.
- LB at addr 0x103, ack after 2 WAIT cycles, rdata 0x80FFFFFF → mem_addr = 0x100; stall_req high 3 cycles; DONE wdata_out = 0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at addr 0x202, data 0x0000ABCD, ack same cycle → mem_wr = 1, mem_sel = 1100, mem_wdata = 0xABCDABCD; DONE we_out = 0; total stall 1 cycle.
- LW at addr 0x006 → no mem_req; exc_misalign pulse in DONE; we_out = 0; next instruction captured the following cycle.
- LW with TIMEOUT_CYC = 4 and no ack → mem_req high 4 WAIT cycles, then dropped; bus_err pulses once; we_out = 0.
- LH in WAIT, flush asserted, ack 2 cycles later → transaction completes; we_out = 0 in DONE; register holds bubble afterwards. rst asserted mid-WAIT → all outputs 0 on the next cycle.
